md_issue_ctrl: RTL and testbench

- Requester side of the multiply/divide unit handshake. Sits between the D and E pipeline stages.
- Accepts MD-class instructions from D, issues a one-cycle start plus opcode to the MD unit, and tracks the unit's latency with a shadow counter.
- Stalls D whenever an MD-class instruction would collide with an in-flight mult/div; the stall also covers mfhi/mflo/mthi/mtlo.

---
 rtl/md_issue_ctrl.sv | 150 +++++++++++++++
 tb/tb_md_issue_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: requester side of the multiply/divide unit handshake, between D and E.
//
// Accepts MD-class instructions from D, issues a one-cycle start pulse plus opcode to the
// MD unit and shadows the unit's latency with a down-counter so that D is held while a
// mult/div is in flight. mfhi/mflo/mthi/mtlo are held by the same window.
//
// Optional feature: define MD_CHECK_EN to compare md_busy_i against the shadow counter
// every cycle and raise a sticky md_err_o on any mismatch. Without it md_err_o is 0 and
// md_busy_i is ignored.
//
// Ports:
//   clk          clock
//   reset        synchronous, active-high reset
//   d_valid_i    D-stage instruction valid
//   d_md_op_i    D-stage MD class: 0 none, 1 mult, 2 multu, 3 div, 4 divu,
//                5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9..15 treated as none
//   d_flush_i    kill the D-stage instruction this cycle
//   md_busy_i    busy from the MD unit
//   stall_d_o    hold D and freeze the PC (combinational)
//   md_start_o   one-cycle start pulse to the MD unit (registered)
//   md_op_o      opcode presented with md_start_o, or 5..8 for one cycle on mf*/mt* accept
//   pred_busy_o  predicted MD-busy window
//   md_err_o     sticky handshake mismatch
module md_issue_ctrl #(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       d_valid_i,
    input  logic [3:0] d_md_op_i,
    input  logic       d_flush_i,
    input  logic       md_busy_i,
    output logic       stall_d_o,
    output logic       md_start_o,
    output logic [3:0] md_op_o,
    output logic       pred_busy_o,
    output logic       md_err_o
);

    localparam int unsigned MaxLat  = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int unsigned CntW    = $clog2(MaxLat + 2);
    // One extra count covers the ISSUE cycle, before the unit raises busy.
    localparam logic [CntW-1:0] MultLoad = CntW'(MULT_LAT + 1);
    localparam logic [CntW-1:0] DivLoad  = CntW'(DIV_LAT + 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitM,
        StWaitD
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            md_start_q, md_start_d;
    logic [3:0]      md_op_q, md_op_d;

    logic is_md, is_long, is_mult, tracking, accept;

    assign is_md   = d_valid_i & ~d_flush_i & (d_md_op_i >= 4'd1) & (d_md_op_i <= 4'd8);
    assign is_long = (d_md_op_i >= 4'd1) & (d_md_op_i <= 4'd4);
    assign is_mult = (d_md_op_i == 4'd1) | (d_md_op_i == 4'd2);

    // Non-idle state is exactly md_start_q | (cnt_q != 0).
    assign tracking = (state_q != StIdle);
    assign accept   = is_md & ~tracking;

    always_comb begin
        cnt_d      = (cnt_q != '0) ? cnt_q - CntW'(1) : '0;
        md_start_d = 1'b0;
        md_op_d    = 4'd0;
        state_d    = state_q;

        if (accept) begin
            md_op_d    = d_md_op_i;
            md_start_d = is_long;
            if (is_long) begin
                cnt_d = is_mult ? MultLoad : DivLoad;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (accept && is_long) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                // md_op_q still holds the long opcode during the issue cycle.
                if (cnt_d == '0) begin
                    state_d = StIdle;
                end else if ((md_op_q == 4'd1) || (md_op_q == 4'd2)) begin
                    state_d = StWaitM;
                end else begin
                    state_d = StWaitD;
                end
            end
            StWaitM, StWaitD: begin
                if (cnt_d == '0) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            md_start_q <= 1'b0;
            md_op_q    <= 4'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            md_start_q <= md_start_d;
            md_op_q    <= md_op_d;
        end
    end

    assign stall_d_o   = is_md & tracking;
    assign md_start_o  = md_start_q;
    assign md_op_o     = md_op_q;
    assign pred_busy_o = tracking;

`ifdef MD_CHECK_EN
    logic err_q;
    logic busy_exp;

    // Busy expected from the cycle after ISSUE until the counter's last nonzero cycle.
    assign busy_exp = ((cnt_q != '0) & ~md_start_q & (cnt_q != CntW'(1))) |
                      (cnt_q == CntW'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (md_busy_i != busy_exp) begin
            err_q <= 1'b1;
        end
    end

    assign md_err_o = err_q;
`else
    logic unused_md_busy;
    assign unused_md_busy = md_busy_i;
    assign md_err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Self-checking bench for md_issue_ctrl: directed scenarios with literal expectations
// plus randomized traffic, all compared every cycle against a cycle-indexed window model.
module tb_md_issue_ctrl;

    localparam int unsigned ML = 5;
    localparam int unsigned DL = 10;

    logic       clk;
    logic       reset;
    logic       d_valid_i;
    logic [3:0] d_md_op_i;
    logic       d_flush_i;
    logic       md_busy_i;
    logic       stall_d_o;
    logic       md_start_o;
    logic [3:0] md_op_o;
    logic       pred_busy_o;
    logic       md_err_o;

    md_issue_ctrl #(
        .MULT_LAT (ML),
        .DIV_LAT  (DL)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .d_valid_i   (d_valid_i),
        .d_md_op_i   (d_md_op_i),
        .d_flush_i   (d_flush_i),
        .md_busy_i   (md_busy_i),
        .stall_d_o   (stall_d_o),
        .md_start_o  (md_start_o),
        .md_op_o     (md_op_o),
        .pred_busy_o (pred_busy_o),
        .md_err_o    (md_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model: cycle index, last blocked cycle, and the MD unit's busy window [bs, be].
    int         t = 0;
    int         busy_until = -1;
    int         bs = 1;
    int         be = 0;
    logic       exp_start = 1'b0;
    logic [3:0] exp_op = 4'd0;
    logic       exp_err = 1'b0;

    logic       s_stall, s_start, s_pb, s_err;
    logic [3:0] s_op;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, t, act, exp);
        end
    endtask

    // One clock cycle: drive inputs just after the edge, compare mid-cycle, advance model.
    task automatic cycle(input logic v, input logic [3:0] op, input logic fl,
                         input logic rst, input logic inj);
        logic is_md, is_long, blocked, correct, acc;
        int   lat;
        correct    = (t >= bs) && (t <= be);
        d_valid_i  = v;
        d_md_op_i  = op;
        d_flush_i  = fl;
        reset      = rst;
        md_busy_i  = correct ^ inj;
        is_md      = v && !fl && (op >= 4'd1) && (op <= 4'd8);
        is_long    = (op >= 4'd1) && (op <= 4'd4);
        blocked    = (t <= busy_until);
        #4;
        s_stall = stall_d_o;
        s_start = md_start_o;
        s_op    = md_op_o;
        s_pb    = pred_busy_o;
        s_err   = md_err_o;
        chk("stall_d", {31'd0, s_stall}, {31'd0, is_md && blocked});
        chk("md_start", {31'd0, s_start}, {31'd0, exp_start});
        chk("md_op", {28'd0, s_op}, {28'd0, exp_op});
        chk("pred_busy", {31'd0, s_pb}, {31'd0, blocked});
        chk("md_err", {31'd0, s_err}, {31'd0, exp_err});
        acc = is_md && !blocked;
        if (rst) begin
            exp_start  = 1'b0;
            exp_op     = 4'd0;
            exp_err    = 1'b0;
            busy_until = t;
            bs         = 1;
            be         = 0;
        end else begin
`ifdef MD_CHECK_EN
            if (md_busy_i != correct) exp_err = 1'b1;
`endif
            exp_start = acc && is_long;
            exp_op    = acc ? op : 4'd0;
            if (acc && is_long) begin
                lat        = (op <= 4'd2) ? ML : DL;
                busy_until = t + 1 + lat;
                bs         = t + 2;
                be         = t + 1 + lat;
            end
        end
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    int n_stall, n_pb, first_start, second_start;

    initial begin
        reset     = 1'b1;
        d_valid_i = 1'b0;
        d_md_op_i = 4'd0;
        d_flush_i = 1'b0;
        md_busy_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state.
        cycle(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("rst_start", {31'd0, s_start}, 0);
        chk("rst_op", {28'd0, s_op}, 0);
        chk("rst_pb", {31'd0, s_pb}, 0);
        chk("rst_err", {31'd0, s_err}, 0);

        // mult at cycle 0, mfhi waiting from cycle 1.
        idle(2);
        cycle(1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            cycle(i <= 7, 4'd5, 1'b0, 1'b0, 1'b0);
            chk("mult_start", {31'd0, s_start}, (i == 1) ? 1 : 0);
            chk("mult_stall", {31'd0, s_stall}, (i >= 1 && i <= 6) ? 1 : 0);
            if (i == 8) chk("mfhi_op", {28'd0, s_op}, 5);
        end

        // divu then div: 11 stalled cycles, starts 12 apart.
        idle(3);
        cycle(1'b1, 4'd4, 1'b0, 1'b0, 1'b0);
        n_stall = 0; first_start = -1; second_start = -1;
        for (int i = 1; i <= 14; i++) begin
            cycle(i <= 12, 4'd3, 1'b0, 1'b0, 1'b0);
            if (s_stall) n_stall++;
            if (s_start && first_start < 0) first_start = i;
            else if (s_start) second_start = i;
        end
        chk("div_stall_cnt", n_stall, 11);
        chk("div_start_gap", second_start - first_start, 12);

        // Flushed mthi while idle.
        idle(12);
        cycle(1'b1, 4'd7, 1'b1, 1'b0, 1'b0);
        chk("flush_stall", {31'd0, s_stall}, 0);
        cycle(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("flush_op", {28'd0, s_op}, 0);

        // mult followed by non-MD stream.
        cycle(1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
        n_stall = 0; n_pb = 0;
        for (int i = 1; i <= 10; i++) begin
            cycle(1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
            if (s_stall) n_stall++;
            if (s_pb) n_pb++;
        end
        chk("add_stall_cnt", n_stall, 0);
        chk("add_pb_cnt", n_pb, 6);

        // Reset in the middle of a div (counter at 7).
        idle(2);
        cycle(1'b1, 4'd4, 1'b0, 1'b0, 1'b0);
        idle(4);
        cycle(1'b1, 4'd1, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
        chk("midrst_stall", {31'd0, s_stall}, 0);
        chk("midrst_start", {31'd0, s_start}, 0);
        chk("midrst_pb", {31'd0, s_pb}, 0);
        chk("midrst_err", {31'd0, s_err}, 0);

`ifdef MD_CHECK_EN
        // MD unit drops busy one cycle early during a mult.
        idle(3);
        cycle(1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 12; i++) begin
            cycle(1'b0, 4'd0, 1'b0, i == 11, i == 6);
            if (i >= 7 && i <= 11) chk("err_sticky", {31'd0, s_err}, 1);
            if (i == 12) chk("err_cleared", {31'd0, s_err}, 0);
        end
`endif

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] rop;
            rop = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                               : 4'($urandom_range(0, 8));
            cycle($urandom_range(0, 3) != 0, rop, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 99) == 0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
